mdu_ctrl: RTL

- Multiply/divide unit sequencer for the 5-stage MIPS pipeline, located in stage E.
- Accepts one MDU operation per start, latches the operands, and models the fixed latency with a cycle counter.
- Drives the busy flag used by the hazard unit's MDU stall check, and owns the HI/LO registers.
- Handles same-cycle cancellation when an exception or interrupt flushes the issuing instruction.

---
 rtl/mdu_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// MIPS stage-E multiply/divide sequencer: fixed-latency busy model plus HI/LO ownership.
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
`endif

  logic [0:0]  state_q, state_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic        issue;
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, mul_p;
  logic        div_signed, rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag, q_mag, r_mag, div_q, div_r;
  logic        is_long;
  logic [3:0]  long_n;
  logic [63:0] res;

  // A start while busy is dropped outright, never queued.
  assign issue = start && !cancel && !busy_q;

`ifdef MDU_MADD_EN
  assign mul_signed = (op == OP_MULT) || (op == OP_MADD);
`else
  assign mul_signed = (op == OP_MULT);
`endif
  assign mul_a = mul_signed ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
  assign mul_b = mul_signed ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
  assign mul_p = mul_a * mul_b;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder follows dividend.
  assign div_signed = (op == OP_DIV);
  assign rs_neg = div_signed && rs_val[31];
  assign rt_neg = div_signed && rt_val[31];
  assign rs_mag = rs_neg ? (~rs_val + 32'd1) : rs_val;
  assign rt_mag = rt_neg ? (~rt_val + 32'd1) : rt_val;
  assign q_mag  = (rt_val == 32'd0) ? 32'd0 : rs_mag / rt_mag;
  assign r_mag  = (rt_val == 32'd0) ? 32'd0 : rs_mag % rt_mag;
  assign div_q  = (rt_val == 32'd0) ? 32'hFFFF_FFFF :
                  ((rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag);
  assign div_r  = (rt_val == 32'd0) ? rs_val :
                  (rs_neg ? (~r_mag + 32'd1) : r_mag);

  always_comb begin
    is_long = 1'b0;
    long_n  = 4'(MULT_CYCLES);
    res     = 64'd0;
    case (op)
      OP_MULT, OP_MULTU: begin
        is_long = 1'b1;
        res     = mul_p;
      end
      OP_DIV, OP_DIVU: begin
        is_long = 1'b1;
        long_n  = 4'(DIV_CYCLES);
        res     = {div_r, div_q};
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        is_long = 1'b1;
        res     = {hi_q, lo_q} + mul_p;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          if (is_long) begin
            pend_hi_d = res[63:32];
            pend_lo_d = res[31:0];
            cnt_d     = long_n;
            state_d   = S_BUSY;
            busy_d    = 1'b1;
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
